// File: rtl/mod_exp_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mod_exp_ctrl
// Computes result = base^exp mod m. The block runs left-to-right binary
// square-and-multiply and uses one external modular multiplier for every
// product. It performs no arithmetic on the accumulator itself; all modular
// reduction is done by the multiplier.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start_p            one-cycle start pulse; accepted only in IDLE or DONE
//   base, exp, m       operands; captured when start_p is accepted
//   mul_en_p           one-cycle request pulse to the multiplier
//   mul_a, mul_b       multiplier operands; held until the product returns
//   mul_m              multiplier modulus; this is the captured modulus itself
//   mul_y, mul_done_p  product, and its one-cycle completion pulse
//   result             final value; held until the next completion
//   busy               high while an exponentiation is in progress
//   done_p             one-cycle completion pulse, coincident with result
// ---------------------------------------------------------------------------
module mod_exp_ctrl #(
  parameter int NBITS = 4096,
  parameter int EBITS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic             mul_en_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             done_p
);

  localparam int CW = $clog2(EBITS + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(EBITS);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [NBITS-1:0] R_ONE    = NBITS'(1);
  localparam logic [EBITS-1:0] E_ZERO   = {EBITS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_SQR_REQ  = 3'd2,
    ST_SQR_WAIT = 3'd3,
    ST_MUL_REQ  = 3'd4,
    ST_MUL_WAIT = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t           state_r;
  logic [NBITS-1:0] base_r;
  logic [NBITS-1:0] r_r;     // running accumulator
  logic [EBITS-1:0] e_r;     // exponent, shifted left; MSB is the current bit
  logic [CW-1:0]    cnt_r;   // exponent bits still to consume

  logic [EBITS-1:0] e_shift_s;
  logic [CW-1:0]    cnt_dec_s;
  logic             last_s;
  logic             bit_s;

  assign e_shift_s = {e_r[EBITS-2:0], 1'b0};
  assign cnt_dec_s = cnt_r - CNT_ONE;
  assign last_s    = (cnt_r == CNT_ONE);  // consuming this bit empties the exponent
  assign bit_s     = e_r[EBITS-1];

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      base_r   <= {NBITS{1'b0}};
      r_r      <= {NBITS{1'b0}};
      e_r      <= {EBITS{1'b0}};
      cnt_r    <= {CW{1'b0}};
      mul_en_p <= 1'b0;
      mul_a    <= {NBITS{1'b0}};
      mul_b    <= {NBITS{1'b0}};
      mul_m    <= {NBITS{1'b0}};
      result   <= {NBITS{1'b0}};
      busy     <= 1'b0;
      done_p   <= 1'b0;
    end else begin
      // Both pulses are single-cycle unless re-armed below.
      mul_en_p <= 1'b0;
      done_p   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_p) begin
            base_r <= base;
            e_r    <= exp;
            mul_m  <= m;
            cnt_r  <= CNT_FULL;
            if (exp == E_ZERO) begin
              // x^0 = 1 without touching the multiplier; busy never rises.
              r_r     <= R_ONE;
              result  <= R_ONE;
              done_p  <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              busy    <= 1'b1;
              state_r <= ST_SCAN;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          // Skip leading zeros; the leading one loads R with the base.
          e_r   <= e_shift_s;
          cnt_r <= cnt_dec_s;
          if (bit_s) begin
            r_r <= base_r;
            if (last_s) begin
              result  <= base_r;
              done_p  <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              mul_a    <= base_r;
              mul_b    <= base_r;
              mul_en_p <= 1'b1;
              state_r  <= ST_SQR_REQ;
            end
          end
        end

        ST_SQR_REQ: begin
          state_r <= ST_SQR_WAIT;
        end

        ST_SQR_WAIT: begin
          if (mul_done_p) begin
            r_r <= mul_y;
            if (bit_s) begin
              // Bit is set: multiply by base before consuming it.
              mul_a    <= mul_y;
              mul_b    <= base_r;
              mul_en_p <= 1'b1;
              state_r  <= ST_MUL_REQ;
            end else begin
              e_r   <= e_shift_s;
              cnt_r <= cnt_dec_s;
              if (last_s) begin
                result  <= mul_y;
                done_p  <= 1'b1;
                busy    <= 1'b0;
                state_r <= ST_DONE;
              end else begin
                mul_a    <= mul_y;
                mul_b    <= mul_y;
                mul_en_p <= 1'b1;
                state_r  <= ST_SQR_REQ;
              end
            end
          end
        end

        ST_MUL_REQ: begin
          state_r <= ST_MUL_WAIT;
        end

        ST_MUL_WAIT: begin
          if (mul_done_p) begin
            r_r   <= mul_y;
            e_r   <= e_shift_s;
            cnt_r <= cnt_dec_s;
            if (last_s) begin
              result  <= mul_y;
              done_p  <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              mul_a    <= mul_y;
              mul_b    <= mul_y;
              mul_en_p <= 1'b1;
              state_r  <= ST_SQR_REQ;
            end
          end
        end

        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
